// File: rtl/pmp_csr_regs_pkg.sv
// Shared PMP types, CSR addresses and the per-byte pmpcfg legalization rule.
package pmp_csr_regs_pkg;

    typedef enum logic [1:0] {
        ADDR_OFF   = 2'b00,
        ADDR_TOR   = 2'b01,
        ADDR_NA4   = 2'b10,
        ADDR_NAPOT = 2'b11
    } pmp_addr_mode_t;

    localparam logic [2:0] ACCESS_NONE  = 3'b000;
    localparam logic [2:0] ACCESS_READ  = 3'b001;
    localparam logic [2:0] ACCESS_WRITE = 3'b010;
    localparam logic [2:0] ACCESS_EXEC  = 3'b100;
    localparam logic [2:0] ACCESS_RWX   = 3'b111;

    // Byte layout: L[7], reserved[6:5], A[4:3], X[2], W[1], R[0].
    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        logic [2:0]     access_type;
    } pmpcfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } mseccfg_t;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPCFG2  = 12'h3A2;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
    localparam logic [11:0] CSR_MSECCFG  = 12'h747;

    // Returns the value a cfg byte takes after a write, judged on pre-write state.
    function automatic pmpcfg_t legalize_cfg(pmpcfg_t old_cfg, logic [7:0] wbyte, mseccfg_t msec);
        pmpcfg_t nxt;
        nxt          = pmpcfg_t'(wbyte);
        nxt.reserved = 2'b00;
        if (old_cfg.locked && !msec.rlb)
            nxt = old_cfg;
        else if (!msec.mml && nxt.access_type[1] && !nxt.access_type[0])
            nxt = old_cfg;
        else if (msec.mml && !msec.rlb && nxt.locked && nxt.access_type[2]
                 && nxt.access_type != ACCESS_RWX)
            nxt = old_cfg;
        return nxt;
    endfunction

endpackage

// File: rtl/pmp_csr_regs.sv
// PMP CSR file: pmpcfg0/2, pmpaddr0-15 and mseccfg with lock/WARL rules,
// single-cycle registered read response.
module pmp_csr_regs
    import pmp_csr_regs_pkg::*;
#(
    parameter int NR_ENTRIES = 16,
    parameter int PMP_LEN    = 54
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     csr_valid_i,
    input  logic                     csr_we_i,
    input  logic [11:0]              csr_addr_i,
    input  logic [63:0]              csr_wdata_i,
    output logic                     csr_rvalid_o,
    output logic [63:0]              csr_rdata_o,
    output logic                     csr_error_o,
    output logic [15:0][PMP_LEN-1:0] conf_addr_o,
    output pmpcfg_t [15:0]           conf_o,
    output mseccfg_t                 mconf_o
);

    pmpcfg_t [15:0]           cfg_q, cfg_d;
    logic [15:0][PMP_LEN-1:0] addr_q, addr_d;
    mseccfg_t                 msec_q, msec_d;
    logic [63:0]              rdata_d;
    logic                     dec_err;
    logic                     wr_en;
    logic                     any_locked;
    logic [15:0]              addr_lock;

    // Unimplemented entries never get written, so they stay zero and need no gating here.
    always_comb begin
        any_locked = 1'b0;
        addr_lock  = '0;
        for (int i = 0; i < 16; i++) begin
            any_locked   = any_locked | cfg_q[i].locked;
            addr_lock[i] = cfg_q[i].locked;
        end
        for (int i = 0; i < 15; i++) begin
            if (cfg_q[i+1].locked && cfg_q[i+1].addr_mode == ADDR_TOR)
                addr_lock[i] = 1'b1;
        end
        if (msec_q.rlb)
            addr_lock = '0;
    end

    always_comb begin
        cfg_d   = cfg_q;
        addr_d  = addr_q;
        msec_d  = msec_q;
        rdata_d = '0;
        dec_err = 1'b0;
        wr_en   = csr_valid_i && csr_we_i;
        if (csr_addr_i == CSR_PMPCFG0 || csr_addr_i == CSR_PMPCFG2) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if ((i >= 8) == (csr_addr_i == CSR_PMPCFG2)) begin
                    rdata_d[8*(i%8) +: 8] = cfg_q[i];
                    if (wr_en)
                        cfg_d[i] = legalize_cfg(cfg_q[i], csr_wdata_i[8*(i%8) +: 8], msec_q);
                end
            end
        end else if (csr_addr_i[11:4] == CSR_PMPADDR0[11:4]) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (csr_addr_i[3:0] == i[3:0]) begin
                    rdata_d[PMP_LEN-1:0] = addr_q[i];
                    if (wr_en && !addr_lock[i])
                        addr_d[i] = csr_wdata_i[PMP_LEN-1:0];
                end
            end
        end else if (csr_addr_i == CSR_MSECCFG) begin
            rdata_d[2:0] = msec_q;
            if (wr_en) begin
                msec_d.mml  = msec_q.mml  | csr_wdata_i[0];
                msec_d.mmwp = msec_q.mmwp | csr_wdata_i[1];
                if (msec_q.rlb || !any_locked)
                    msec_d.rlb = csr_wdata_i[2];
            end
        end else begin
            dec_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q        <= '0;
            addr_q       <= '0;
            msec_q       <= '0;
            csr_rvalid_o <= 1'b0;
            csr_rdata_o  <= '0;
            csr_error_o  <= 1'b0;
        end else begin
            cfg_q        <= cfg_d;
            addr_q       <= addr_d;
            msec_q       <= msec_d;
            csr_rvalid_o <= csr_valid_i;
            csr_rdata_o  <= csr_valid_i ? rdata_d : '0;
            csr_error_o  <= csr_valid_i & dec_err;
        end
    end

    assign conf_o      = cfg_q;
    assign conf_addr_o = addr_q;
    assign mconf_o     = msec_q;

endmodule

// File: tb/tb_pmp_csr_regs.sv
// Directed + random bench for pmp_csr_regs against a rule-level reference model.
module tb_pmp_csr_regs;
    import pmp_csr_regs_pkg::*;

    localparam int NR = 12;
    localparam int PL = 54;

    logic                clk = 1'b0;
    logic                rst;
    logic                csr_valid, csr_we;
    logic [11:0]         csr_addr;
    logic [63:0]         csr_wdata;
    logic                csr_rvalid;
    logic [63:0]         csr_rdata;
    logic                csr_error;
    logic [15:0][PL-1:0] conf_addr;
    pmpcfg_t [15:0]      conf;
    mseccfg_t            mconf;

    pmp_csr_regs #(.NR_ENTRIES(NR), .PMP_LEN(PL)) dut (
        .clk_i(clk), .rst_i(rst), .csr_valid_i(csr_valid), .csr_we_i(csr_we),
        .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .csr_rvalid_o(csr_rvalid),
        .csr_rdata_o(csr_rdata), .csr_error_o(csr_error), .conf_addr_o(conf_addr),
        .conf_o(conf), .mconf_o(mconf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference state
    logic [7:0]  m_cfg [16];
    logic [63:0] m_addr[16];
    logic        m_mml, m_mmwp, m_rlb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_cfg[i]  = 8'h00;
            m_addr[i] = 64'h0;
        end
        m_mml = 1'b0; m_mmwp = 1'b0; m_rlb = 1'b0;
    endtask

    // Model of one access: returns response, applies write rules to pre-write state.
    task automatic m_access(input logic we, input logic [11:0] a, input logic [63:0] wd,
                            output logic [63:0] rd, output logic err);
        int  base, idx;
        logic any_l, lk;
        logic [7:0] nb;
        logic [7:0] old_cfg[16];
        rd = 64'h0; err = 1'b1;
        for (int i = 0; i < 16; i++) old_cfg[i] = m_cfg[i];
        any_l = 1'b0;
        for (int i = 0; i < NR; i++) if (old_cfg[i][7]) any_l = 1'b1;
        if (a == 12'h3A0 || a == 12'h3A2) begin
            err  = 1'b0;
            base = (a == 12'h3A2) ? 8 : 0;
            for (int b = 0; b < 8; b++) begin
                idx = base + b;
                if (idx < NR) begin
                    rd[8*b +: 8] = old_cfg[idx];
                    if (we) begin
                        nb = wd[8*b +: 8] & 8'h9F;
                        if (!(old_cfg[idx][7] && !m_rlb) &&
                            !(!m_mml && nb[1:0] == 2'b10) &&
                            !(m_mml && !m_rlb && nb[7] && nb[2] && nb[2:0] != 3'b111))
                            m_cfg[idx] = nb;
                    end
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            err = 1'b0;
            idx = int'(a - 12'h3B0);
            if (idx < NR) begin
                rd = m_addr[idx];
                lk = old_cfg[idx][7];
                if (idx < 15 && old_cfg[idx+1][7] && old_cfg[idx+1][4:3] == 2'b01) lk = 1'b1;
                if (m_rlb) lk = 1'b0;
                if (we && !lk) m_addr[idx] = wd & ((64'h1 << PL) - 64'h1);
            end
        end else if (a == 12'h747) begin
            err = 1'b0;
            rd  = {61'h0, m_rlb, m_mmwp, m_mml};
            if (we) begin
                if (m_rlb || !any_l) m_rlb = wd[2];
                m_mml  = m_mml  | wd[0];
                m_mmwp = m_mmwp | wd[1];
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s conf[%0d]", tag, i), {56'h0, conf[i]}, {56'h0, m_cfg[i]});
            chk($sformatf("%s addr[%0d]", tag, i), {{(64-PL){1'b0}}, conf_addr[i]}, m_addr[i]);
        end
        chk({tag, " mseccfg"}, {61'h0, mconf}, {61'h0, m_rlb, m_mmwp, m_mml});
    endtask

    task automatic do_req(input logic we, input logic [11:0] a, input logic [63:0] wd);
        logic [63:0] erd;
        logic        eerr;
        @(negedge clk);
        csr_valid = 1'b1; csr_we = we; csr_addr = a; csr_wdata = wd;
        m_access(we, a, wd, erd, eerr);
        @(negedge clk);
        csr_valid = 1'b0;
        chk($sformatf("rvalid %h", a), {63'h0, csr_rvalid}, 64'h1);
        chk($sformatf("rdata %h", a), csr_rdata, erd);
        chk($sformatf("error %h", a), {63'h0, csr_error}, {63'h0, eerr});
        check_outputs($sformatf("after %h", a));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        chk("reset rvalid", {63'h0, csr_rvalid}, 64'h0);
        chk("reset rdata", csr_rdata, 64'h0);
        chk("reset error", {63'h0, csr_error}, 64'h0);
        check_outputs("reset");
    endtask

    logic [11:0] addr_pool[8];

    initial begin
        rst = 1'b1; csr_valid = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
        m_reset();
        @(negedge clk);
        do_reset();

        // cfg0 TOR RWX, cfg1 NAPOT RWX
        do_req(1'b1, 12'h3A0, 64'h0000_0000_0000_1F0F);
        do_req(1'b0, 12'h3A0, 64'h0);
        chk("cfg readback", csr_rdata, 64'h1F0F);
        chk("cfg0 TOR", {62'h0, conf[0].addr_mode}, 64'h1);
        chk("cfg1 NAPOT RWX", {56'h0, conf[1]}, 64'h1F);

        // TOR lock of entry 1 protects pmpaddr0, own L protects pmpaddr1
        do_req(1'b1, 12'h3B0, 64'h55);
        do_req(1'b1, 12'h3B1, 64'h66);
        do_req(1'b1, 12'h3A0, 64'h0000_0000_0000_8F0F);
        do_req(1'b1, 12'h3B0, 64'h1000);
        chk("pmpaddr0 TOR locked", {10'h0, conf_addr[0]}, 64'h55);
        do_req(1'b1, 12'h3B1, 64'h2000);
        chk("pmpaddr1 locked", {10'h0, conf_addr[1]}, 64'h66);
        do_req(1'b1, 12'h3A0, 64'h0);
        chk("cfg1 locked byte", {56'h0, conf[1]}, 64'h8F);
        do_reset();

        // sticky MML
        do_req(1'b1, 12'h747, 64'h1);
        do_req(1'b1, 12'h747, 64'h0);
        chk("mml sticky", {63'h0, mconf.mml}, 64'h1);
        do_reset();
        chk("mml after reset", {63'h0, mconf.mml}, 64'h0);

        // reserved W-only encoding keeps old byte
        do_req(1'b1, 12'h3A0, 64'h05);
        do_req(1'b1, 12'h3A0, 64'h02);
        chk("W-only kept", {56'h0, conf[0]}, 64'h05);
        do_req(1'b1, 12'h3A0, 64'hFF);
        chk("reserved bits zero", {56'h0, conf[0]}, 64'h9F);
        do_reset();

        // illegal address
        do_req(1'b0, 12'h3A1, 64'h0);
        chk("3A1 error", {63'h0, csr_error}, 64'h1);
        do_req(1'b1, 12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF);
        do_req(1'b1, 12'h3A3, 64'h0F0F_0F0F_0F0F_0F0F);

        // unimplemented entries 12..15
        do_req(1'b1, 12'h3A2, 64'h0F0F_0F0F_0F0F_0F0F);
        do_req(1'b0, 12'h3A2, 64'h0);
        chk("cfg2 upper zero", csr_rdata, 64'h0000_0000_0F0F_0F0F);
        do_req(1'b1, 12'h3BE, 64'h1234);
        do_req(1'b0, 12'h3BE, 64'h0);
        do_req(1'b1, 12'h3B5, 64'hFFFF_FFFF_FFFF_FFFF);
        do_reset();

        // back-to-back write then read of pmpaddr3
        do_req(1'b1, 12'h3B3, 64'h1111);
        @(negedge clk);
        csr_valid = 1'b1; csr_we = 1'b1; csr_addr = 12'h3B3; csr_wdata = 64'hABCD;
        @(negedge clk);
        csr_we = 1'b0;
        chk("b2b first rvalid", {63'h0, csr_rvalid}, 64'h1);
        chk("b2b first rdata", csr_rdata, 64'h1111);
        @(negedge clk);
        csr_valid = 1'b0;
        chk("b2b second rvalid", {63'h0, csr_rvalid}, 64'h1);
        chk("b2b second rdata", csr_rdata, 64'hABCD);
        m_addr[3] = 64'hABCD;
        @(negedge clk);
        chk("b2b idle rvalid", {63'h0, csr_rvalid}, 64'h0);

        // request in a reset cycle gets no response
        @(negedge clk);
        csr_valid = 1'b1; csr_we = 1'b1; csr_addr = 12'h3B2; csr_wdata = 64'h77; rst = 1'b1;
        @(negedge clk);
        csr_valid = 1'b0; rst = 1'b0;
        m_reset();
        chk("rst req rvalid", {63'h0, csr_rvalid}, 64'h0);
        @(negedge clk);
        chk("rst req no late rvalid", {63'h0, csr_rvalid}, 64'h0);
        check_outputs("rst req");

        // random traffic
        addr_pool[0] = 12'h3A0; addr_pool[1] = 12'h3A2; addr_pool[2] = 12'h3B0;
        addr_pool[3] = 12'h747; addr_pool[4] = 12'h3A1; addr_pool[5] = 12'h3A3;
        addr_pool[6] = 12'h3B0; addr_pool[7] = 12'h000;
        for (int n = 0; n < 300; n++) begin
            logic [11:0] a;
            logic [63:0] wd;
            int sel;
            if ($urandom_range(0, 39) == 0) do_reset();
            sel = int'($urandom_range(0, 7));
            a   = addr_pool[sel];
            if (sel == 2 || sel == 6) a = 12'h3B0 + 12'($urandom_range(0, 15));
            if (sel == 7) a = 12'($urandom);
            wd = {$urandom, $urandom};
            do_req(1'($urandom_range(0, 2) != 0), a, wd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
